// File: rtl/ref_clk_gen.sv
// ref_clk_gen: programmable square-wave reference clock for the ADPLL ref_clk_i input.
//   fpga_clk_i     system clock, all logic on its rising edge
//   reset_i        asynchronous active-high reset
//   enable_i       run request, sampled only at the end of a low phase
//   half_period_i  requested half period, captured when load_i=1
//   load_ack_o     pulses on the rising edge where a loaded half period takes effect
//   phase_step_i   signed cycle offset for one high phase, handshaked by step_valid_i/step_ready_o
//   ref_clk_o      generated clock (registered), edge_o strobes with each 0->1 transition
//   Optional: define REF_CLK_JITTER_EN for an 8-bit LFSR that adds +/-1 cycle to each phase.
module ref_clk_gen #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 40,
  parameter int MIN_HALF     = 2
) (
  input  logic              fpga_clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [CNT_W-1:0]  half_period_i,
  input  logic              load_i,
  output logic              load_ack_o,
  input  logic signed [7:0] phase_step_i,
  input  logic              step_valid_i,
  output logic              step_ready_o,
  output logic              ref_clk_o,
  output logic              edge_o
);
  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_HALF);
  localparam logic signed [SW-1:0] MAX_S = $signed({2'b00, {CNT_W{1'b1}}});
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  function automatic logic [CNT_W-1:0] clamp(input logic signed [SW-1:0] v);
    return (v < MIN_S) ? CNT_W'(MIN_HALF) : (v > MAX_S) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt, r_term, r_half, r_load_val;
  logic              r_load_pend, r_step_pend, r_ref, r_edge, r_ack, r_ready;
  logic signed [7:0] r_step;
  logic [CNT_W-1:0]  w_h_new, w_hh, w_term_hi, w_term_lo;
  logic              w_end, w_rise, w_fall, w_stop, w_accept;
  assign w_end    = r_cnt == r_term;
  assign w_rise   = enable_i && (r_state == IDLE || (r_state == LOW && w_end));
  assign w_fall   = r_state == HIGH && w_end;
  assign w_stop   = r_state == LOW && w_end && !enable_i;
  assign w_accept = step_valid_i && r_ready;
  // A pending load lands on the same rising edge as a pending step, so the step uses the new H.
  assign w_h_new  = r_load_pend ? clamp($signed({2'b00, r_load_val})) : r_half;
  assign w_hh     = r_step_pend ? clamp($signed({2'b00, w_h_new}) + $signed({{(SW-8){r_step[7]}}, r_step})) : w_h_new;
`ifdef REF_CLK_JITTER_EN
  logic [7:0]           r_lfsr;
  logic signed [SW-1:0] w_adj;
  assign w_adj     = (r_lfsr[1:0] == 2'b01) ? SW'(1) : (r_lfsr[1:0] == 2'b10) ? '1 : '0;
  assign w_term_hi = clamp($signed({2'b00, w_hh}) + w_adj);
  assign w_term_lo = clamp($signed({2'b00, r_half}) + w_adj);
  // Galois form of x^8+x^6+x^5+x^4+1, stepped once per phase boundary.
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i) r_lfsr <= 8'hA5;
    else if (w_rise || w_fall) r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
`else
  assign w_term_hi = w_hh;
  assign w_term_lo = r_half;
`endif
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_term      <= '0;
      r_half      <= CNT_W'(DEFAULT_HALF);
      r_load_pend <= 1'b0;
      r_load_val  <= '0;
      r_step_pend <= 1'b0;
      r_step      <= '0;
      r_ref       <= 1'b0;
      r_edge      <= 1'b0;
      r_ack       <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_edge  <= w_rise;
      r_ack   <= w_rise && r_load_pend;
      // Ready stays low through the rising edge that consumes the step and returns one cycle later.
      r_ready <= !(w_accept || r_step_pend);
      if (w_rise) begin
        r_state     <= HIGH;
        r_ref       <= 1'b1;
        r_cnt       <= CNT_W'(1);
        r_term      <= w_term_hi;
        r_half      <= w_h_new;
        r_load_pend <= 1'b0;
        r_step_pend <= 1'b0;
      end else if (w_fall) begin
        r_state <= LOW;
        r_ref   <= 1'b0;
        r_cnt   <= CNT_W'(1);
        r_term  <= w_term_lo;
      end else if (w_stop) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state != IDLE) r_cnt <= r_cnt + 1'b1;
      // Loads seen on the application edge override the clear above and wait for the next rise.
      if (load_i) begin
        r_load_pend <= 1'b1;
        r_load_val  <= half_period_i;
      end
      if (w_accept) begin
        r_step_pend <= 1'b1;
        r_step      <= phase_step_i;
      end
    end
  assign ref_clk_o    = r_ref;
  assign edge_o       = r_edge;
  assign load_ack_o   = r_ack;
  assign step_ready_o = r_ready;
endmodule

// File: tb/tb_ref_clk_gen.sv
// tb_ref_clk_gen: scoreboard bench comparing measured ref_clk_o periods against a period-level model.
`timescale 1ns/1ps
module tb_ref_clk_gen;
  localparam int MINH = 2;
  logic clk = 1'b0, rst = 1'b1, enable_i = 1'b0, load_i = 1'b0, step_valid_i = 1'b0;
  logic [15:0] half_period_i = '0;
  logic signed [7:0] phase_step_i = '0;
  logic load_ack_o, step_ready_o, ref_clk_o, edge_o;
  int checks = 0, errors = 0;
  typedef struct {int hi; int lo; int ack;} rec_t;
  rec_t exp_q[$];
  rec_t mon_r;
  int m_h = 40, m_lv = 0, m_sv = 0, late_lv = 0;
  bit m_lp = 0, m_sp = 0, late_lp = 0;
  bit mon_open = 0, prev_ref = 0, mon_rise;
  int mon_hi = 0, mon_lo = 0, mon_ack = 0;
  always #5 clk = ~clk;
  ref_clk_gen dut (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(enable_i), .half_period_i(half_period_i),
    .load_i(load_i), .load_ack_o(load_ack_o), .phase_step_i(phase_step_i),
    .step_valid_i(step_valid_i), .step_ready_o(step_ready_o), .ref_clk_o(ref_clk_o), .edge_o(edge_o)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int clampi(input int v);
    return v < MINH ? MINH : (v > 65535 ? 65535 : v);
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      mon_open = 0;
      prev_ref = 0;
    end else begin
      mon_rise = ref_clk_o && !prev_ref;
      if (edge_o || mon_rise) chk("edge_o", edge_o, mon_rise);
      if (load_ack_o && !mon_rise) chk("ack_off_edge", load_ack_o, 0);
      if (mon_rise) begin
        if (mon_open) begin
          chk("period_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_r = exp_q.pop_front();
            chk("high_len", mon_hi, mon_r.hi);
            chk("low_len", mon_lo, mon_r.lo);
            chk("load_ack", mon_ack, mon_r.ack);
          end
        end
        mon_open = 1;
        mon_hi = 1;
        mon_lo = 0;
        mon_ack = load_ack_o;
      end else if (ref_clk_o) mon_hi++;
      else mon_lo++;
      prev_ref = ref_clk_o;
    end
  end
  // Called at the negedge just before a rising edge of ref_clk_o; drives one full period.
  task automatic run_period(input int lo, input int lv, input int so, input int sv,
                            input bit stop, input int gap, input int il, input int ro);
    int h, hh, plen;
    bit ack, stepped;
    ack = m_lp;
    if (m_lp) m_h = m_lv < MINH ? MINH : m_lv;
    stepped = m_sp;
    hh = m_sp ? clampi(m_h + m_sv) : m_h;
    h = m_h;
    m_lp = late_lp;
    m_lv = late_lv;
    late_lp = 0;
    m_sp = 0;
    plen = hh + h;
    if (lo < 0) lo = $urandom_range(plen, 1);
    if (so < 0) so = $urandom_range(plen - 1, 2);
    for (int o = 1; o <= plen; o++) begin
      @(negedge clk);
      load_i = 0;
      step_valid_i = 0;
      if (stepped && o == 1) chk("ready_low_at_apply", step_ready_o, 0);
      if (stepped && o == 2) chk("ready_back", step_ready_o, 1);
      if (so > 0 && o == so + 1) chk("ready_after_accept", step_ready_o, 0);
      if (o == lo) begin
        load_i = 1;
        half_period_i = 16'(lv);
        if (o == plen) begin late_lp = 1; late_lv = lv; end
        else begin m_lp = 1; m_lv = lv; end
      end
      if (o == so) begin
        chk("ready_before_step", step_ready_o, 1);
        step_valid_i = 1;
        phase_step_i = 8'(sv);
        m_sp = 1;
        m_sv = sv;
      end
      if (stop && o == 1) enable_i = 0;
      if (o == ro) begin
        #1 rst = 1;
        load_i = 0;
        step_valid_i = 0;
        #1;
        chk("rst_ref", ref_clk_o, 0);
        chk("rst_ready", step_ready_o, 1);
        chk("rst_ack", load_ack_o, 0);
        chk("rst_edge", edge_o, 0);
        m_h = 40; m_lp = 0; m_sp = 0; late_lp = 0;
        @(negedge clk);
        #1 rst = 0;
        return;
      end
    end
    if (stop) begin
      if (late_lp) begin m_lp = 1; m_lv = late_lv; late_lp = 0; end
      for (int g = 1; g <= gap; g++) begin
        @(negedge clk);
        load_i = 0;
        step_valid_i = 0;
        if (g == 1 && il > 0) begin
          load_i = 1;
          half_period_i = 16'(il);
          m_lp = 1;
          m_lv = il;
        end
        if (g == gap) enable_i = 1;
      end
    end
    exp_q.push_back('{hi: hh, lo: plen - hh + (stop ? gap : 0), ack: int'(ack)});
  endtask
  initial begin
    int lo, lv, so, sv, il;
    bit st;
    byte b;
    repeat (2) @(negedge clk);
    chk("reset_ref", ref_clk_o, 0);
    chk("reset_edge", edge_o, 0);
    chk("reset_ack", load_ack_o, 0);
    chk("reset_ready", step_ready_o, 1);
    #1 rst = 0;
    enable_i = 1;
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(10, 20, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(5, 40, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 45, 10, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 3, -45, 0, 0, 0, 0);
    run_period(20, 1, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(4, 40, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(0, 0, 0, 0, 1, 5, 25, 0);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    run_period(10, 40, 0, 0, 0, 0, 0, 0);
    run_period(1, 20, 2, 5, 0, 0, 0, 3);
    run_period(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      lo = $urandom_range(1, 0) != 0 ? -1 : 0;
      lv = $urandom_range(30, 0);
      so = $urandom_range(2, 0) == 0 ? -1 : 0;
      b = byte'($urandom);
      sv = b;
      st = $urandom_range(5, 0) == 0;
      il = (st && $urandom_range(1, 0) != 0) ? $urandom_range(30, 1) : 0;
      run_period(lo, lv, so, sv, st, $urandom_range(6, 2), il, 0);
    end
    repeat (3) @(negedge clk);
    chk("periods_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ref_clk_gen.md
Name: ref_clk_gen

Overview:
Programmable reference-clock source that drives the ADPLL `ref_clk_i`. It is the transmitting end of the reference path that the ADPLL phase detector receives.
- Divides `fpga_clk_i` (400 MHz) into a square wave with a runtime-programmable half period.
- Supports glitch-free frequency changes and one-shot phase steps, so the lock and tracking of the loop can be exercised in simulation and on the board.

Parameters:
CNT_W, 16, width of half-period counter and half-period value
DEFAULT_HALF, 40, half period in fpga_clk_i cycles after reset (400 MHz / 80 = 5 MHz)
MIN_HALF, 2, smallest half period ever applied; smaller requests are clamped to this

Ports:
fpga_clk_i  in  1  system clock; all logic on its rising edge
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  run request; low stops the output low after the current cycle
half_period_i  in  CNT_W  new half period (unsigned), sampled when load_i=1
load_i  in  1  single-cycle request to replace the half period
load_ack_o  out  1  one-cycle pulse when the loaded half period takes effect
phase_step_i  in  8  signed cycles added to one high phase
step_valid_i  in  1  phase-step valid
step_ready_o  out  1  phase-step ready; high when no step is pending
ref_clk_o  out  1  generated reference clock, registered
edge_o  out  1  one-cycle pulse, coincident with ref_clk_o 0->1

Behaviour:
- Reset values:
  - ref_clk_o=0, edge_o=0, load_ack_o=0, step_ready_o=1.
  - Counter=0; active half=DEFAULT_HALF; no pending load; no pending step; state IDLE.
- States and transitions (count = fpga_clk_i cycles spent in the current phase):
  - IDLE: ref_clk_o=0. On enable_i=1 go to HIGH. ref_clk_o and edge_o are 1 on the next edge.
  - HIGH: ref_clk_o=1 for exactly Hh cycles, then go to LOW.
  - LOW: ref_clk_o=0 for exactly H cycles.
    - At the terminal count with enable_i=1: go to HIGH (rising edge, edge_o=1).
    - At the terminal count with enable_i=0: go to IDLE.
  - enable_i is only sampled at the end of LOW, so a truncated pulse is never produced.
- Half-period load:
  - load_i=1 captures half_period_i into a pending register. A later load before it is applied overwrites it; last one wins.
  - The pending value becomes the active H only at the cycle of the next 0->1 transition. load_ack_o pulses in that same cycle.
  - Values below MIN_HALF are applied as MIN_HALF.
  - If load_i and the application cycle coincide, the new request stays pending for the following rising edge.
- Phase step:
  - A step is accepted when step_valid_i && step_ready_o. step_ready_o drops in the next cycle.
  - The step applies to the next HIGH phase that starts after acceptance: Hh = clamp(H + phase_step_i, MIN_HALF, 2^CNT_W-1).
    - Signed arithmetic is done in CNT_W+2 bits.
    - The HIGH phase already in progress is unaffected.
  - Other HIGH phases use Hh = H.
  - step_ready_o returns to 1 in the cycle after that HIGH phase begins.
  - A step and a load landing on the same rising edge are combined: the new H is used in the clamp.
- enable_i low while IDLE: no load/step application. Loads and steps stay pending until the next rising edge.
- reset_i asserted mid-phase: all state returns immediately (asynchronously) to reset values; pending load and step are discarded.

Optional Feature:
REF_CLK_JITTER_EN
- With the macro defined:
  - An 8-bit Galois LFSR (taps 8,6,5,4; seed 8'hA5) advances once per phase boundary.
  - Bits [1:0] select the adjustment to the phase's length: 01 -> +1 cycle, 10 -> -1 cycle, 00/11 -> 0. The result is still clamped to MIN_HALF.
  - The LFSR resets to the seed.
- Without it: no LFSR is present and phase lengths are exact.

Test Plan:
- Reset, then enable_i=1 with defaults -> ref_clk_o high 40 / low 40 cycles; edge_o every 80 cycles; load_ack_o=0; step_ready_o=1.
- Load 20 issued 10 cycles into a HIGH phase -> that high completes at 40 cycles and the following low is 40. The next rising edge gives load_ack_o=1, then 20/20 thereafter.
- Step +10 accepted mid-LOW with H=40 -> next high lasts 50 cycles, subsequent highs 40. step_ready_o low from acceptance+1 until that high begins +1.
- Step -45 with H=40, and separately load 1 -> high phase clamped to 2 cycles; load gives 2/2 period.
- enable_i dropped mid-HIGH -> remaining high and full low complete, then ref_clk_o stays 0 and no edge_o. Re-enable gives edge_o on the next cycle.
- reset_i pulsed during HIGH with a pending load of 20 and a pending step -> ref_clk_o=0 immediately. After re-enable the period is 40/40 and no load_ack_o is produced.
